// File: rtl/axi_slv_pkg.sv
// Shared types and constants for the AXI4 SRAM slave: FSM states, response codes
// and the channel field widths of the AXI define header.
package axi_slv_pkg;

  localparam int unsigned AXI_LEN_W   = 4;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_RESP_W  = 2;

  localparam logic [AXI_RESP_W-1:0]  RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0]  RESP_SLVERR = 2'b10;
  localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RPREP,
    ST_RDATA,
    ST_WDATA,
    ST_WRESP
  } slv_state_t;

  // Byte strobes to active-low SRAM bit-write enables, one byte lane per strobe bit.
  function automatic logic [31:0] strb_to_bweb(input logic [3:0] strb);
    logic [31:0] bweb;
    bweb = '1;
    for (int unsigned i = 0; i < 4; i++) begin
      bweb[8*i +: 8] = {8{~strb[i]}};
    end
    return bweb;
  endfunction

endpackage

// File: rtl/axi_sram_slave.sv
// AXI4 slave terminating one interconnect port onto a single-port synchronous SRAM.
// One transaction at a time, INCR bursts of 1-16 beats, one beat per cycle.
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int unsigned ID_W    = 8,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SRAM_AW = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ID_W-1:0]        ARID,
  input  logic [ADDR_W-1:0]      ARADDR,
  input  logic [AXI_LEN_W-1:0]   ARLEN,
  input  logic [AXI_SIZE_W-1:0]  ARSIZE,
  input  logic [AXI_BURST_W-1:0] ARBURST,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [ID_W-1:0]        RID,
  output logic [DATA_W-1:0]      RDATA,
  output logic [AXI_RESP_W-1:0]  RRESP,
  output logic                   RLAST,
  output logic                   RVALID,
  input  logic                   RREADY,
  input  logic [ID_W-1:0]        AWID,
  input  logic [ADDR_W-1:0]      AWADDR,
  input  logic [AXI_LEN_W-1:0]   AWLEN,
  input  logic [AXI_SIZE_W-1:0]  AWSIZE,
  input  logic [AXI_BURST_W-1:0] AWBURST,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [DATA_W-1:0]      WDATA,
  input  logic [DATA_W/8-1:0]    WSTRB,
  input  logic                   WLAST,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [ID_W-1:0]        BID,
  output logic [AXI_RESP_W-1:0]  BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  output logic                   SRAM_CEB,
  output logic                   SRAM_WEB,
  output logic [DATA_W-1:0]      SRAM_BWEB,
  output logic [SRAM_AW-1:0]     SRAM_A,
  output logic [DATA_W-1:0]      SRAM_DI,
  input  logic [DATA_W-1:0]      SRAM_DO
);

  slv_state_t           state;
  logic [SRAM_AW-1:0]   addr;
  logic [AXI_LEN_W-1:0] len;
  logic [AXI_LEN_W-1:0] cnt;
  logic                 err;
  logic                 last_beat;
  logic                 wlast_bad;

  assign last_beat = (cnt == len);
  assign wlast_bad = (WLAST != last_beat);

  // Size and burst type are fixed by this slave; upper address bits are decoded upstream.
  logic unused_ok;
  assign unused_ok = ^{ARSIZE, AWSIZE, (ARBURST == BURST_INCR), (AWBURST == BURST_INCR),
                       ARADDR[ADDR_W-1:SRAM_AW+2], ARADDR[1:0],
                       AWADDR[ADDR_W-1:SRAM_AW+2], AWADDR[1:0]};

  assign ARREADY = (state == ST_IDLE);
  assign AWREADY = (state == ST_IDLE) && !ARVALID;
  assign RDATA   = SRAM_DO;
  assign RRESP   = RESP_OKAY;
  assign SRAM_DI = WDATA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr   <= '0;
      len    <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      RID    <= '0;
      BID    <= '0;
      RVALID <= 1'b0;
      RLAST  <= 1'b0;
      WREADY <= 1'b0;
      BVALID <= 1'b0;
      BRESP  <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ARVALID) begin
            RID   <= ARID;
            addr  <= ARADDR[SRAM_AW+1:2];
            len   <= ARLEN;
            cnt   <= '0;
            state <= ST_RPREP;
          end else if (AWVALID) begin
            BID    <= AWID;
            addr   <= AWADDR[SRAM_AW+1:2];
            len    <= AWLEN;
            cnt    <= '0;
            WREADY <= 1'b1;
            state  <= ST_WDATA;
          end
        end
        ST_RPREP: begin
          RVALID <= 1'b1;
          RLAST  <= last_beat;
          state  <= ST_RDATA;
        end
        ST_RDATA: begin
          if (RREADY) begin
            addr <= addr + 1'b1;
            cnt  <= cnt + 1'b1;
            if (RLAST) begin
              RVALID <= 1'b0;
              RLAST  <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              RLAST <= (cnt + 4'd1 == len);
            end
          end
        end
        ST_WDATA: begin
          if (WVALID) begin
            addr <= addr + 1'b1;
            cnt  <= cnt + 1'b1;
            if (wlast_bad) err <= 1'b1;
            // Beat count, not WLAST, closes the burst; WLAST only grades the response.
            if (last_beat) begin
              WREADY <= 1'b0;
              BVALID <= 1'b1;
              BRESP  <= (err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              state  <= ST_WRESP;
            end
          end
        end
        ST_WRESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            err    <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    SRAM_CEB  = 1'b1;
    SRAM_WEB  = 1'b1;
    SRAM_BWEB = '1;
    SRAM_A    = addr;
    case (state)
      ST_RPREP: SRAM_CEB = 1'b0;
      ST_RDATA: begin
        // Prefetch the next word on a handshake; re-read the current one on a stall.
        SRAM_CEB = 1'b0;
        SRAM_A   = RREADY ? addr + 1'b1 : addr;
      end
      ST_WDATA: begin
        if (WVALID) begin
          SRAM_CEB  = 1'b0;
          SRAM_WEB  = 1'b0;
          SRAM_BWEB = strb_to_bweb(WSTRB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: directed scenarios plus randomized bursts, checked
// against a word-array reference memory updated from the AXI transactions.
module tb_axi_sram_slave;

  localparam int unsigned ID_W  = 8;
  localparam int unsigned SAW   = 14;
  localparam int unsigned DEPTH = 1 << SAW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ARID = '0, AWID = '0, RID, BID;
  logic [31:0] ARADDR = '0, AWADDR = '0, RDATA, WDATA = '0;
  logic [3:0]  ARLEN = '0, AWLEN = '0, WSTRB = '0;
  logic [2:0]  ARSIZE = 3'd2, AWSIZE = 3'd2;
  logic [1:0]  ARBURST = 2'b01, AWBURST = 2'b01, RRESP, BRESP;
  logic        ARVALID = 1'b0, ARREADY, RLAST, RVALID, RREADY = 1'b0;
  logic        AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
  logic        BVALID, BREADY = 1'b0;
  logic        SRAM_CEB, SRAM_WEB;
  logic [31:0] SRAM_BWEB, SRAM_DI, SRAM_DO;
  logic [13:0] SRAM_A;

  always #5 clk = ~clk;

  axi_sram_slave #(.ID_W(ID_W), .ADDR_W(32), .DATA_W(32), .SRAM_AW(SAW)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_BWEB(SRAM_BWEB), .SRAM_A(SRAM_A),
    .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
  );

  // SRAM macro behaviour: registered read data, bit-masked writes.
  logic [31:0] sram    [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (!SRAM_CEB) begin
      if (!SRAM_WEB) sram[SRAM_A] <= (sram[SRAM_A] & SRAM_BWEB) | (SRAM_DI & ~SRAM_BWEB);
      else           SRAM_DO <= sram[SRAM_A];
    end
  end

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned word_of(input logic [31:0] addr, input int unsigned beat);
    return ((addr >> 2) + beat) % DEPTH;
  endfunction

  // Called at a negedge with the bus idle. bad_last >= 0 puts WLAST on that beat only.
  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input int bad_last, input logic [1:0] exp_resp);
    int unsigned t;
    int unsigned wa;
    logic [31:0] bw;
    AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
    #1;
    t = 0;
    while (AWREADY !== 1'b1 && t < 100) begin @(negedge clk); #1; t++; end
    if (t >= 100) check("aw_timeout", {31'd0, AWREADY}, 32'd1);
    @(negedge clk);
    AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if ($urandom_range(3) == 0) begin
        WVALID = 1'b0;
        #1;
        check("w_gap_ceb", {31'd0, SRAM_CEB}, 32'd1);
        check("w_gap_wready", {31'd0, WREADY}, 32'd1);
        @(negedge clk);
      end
      wa = word_of(addr, b);
      WVALID = 1'b1; WDATA = wdat[b]; WSTRB = wstb[b];
      WLAST = (bad_last >= 0) ? (b == bad_last) : (b == int'(len));
      #1;
      check("wready", {31'd0, WREADY}, 32'd1);
      check("w_ceb", {31'd0, SRAM_CEB}, 32'd0);
      check("w_web", {31'd0, SRAM_WEB}, 32'd0);
      check("w_addr", {18'd0, SRAM_A}, wa);
      check("w_di", SRAM_DI, wdat[b]);
      bw = '1;
      for (int k = 0; k < 4; k++) if (wstb[b][k]) bw[8*k +: 8] = 8'h00;
      check("w_bweb", SRAM_BWEB, bw);
      for (int k = 0; k < 4; k++) if (wstb[b][k]) ref_mem[wa][8*k +: 8] = wdat[b][8*k +: 8];
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    repeat ($urandom_range(2)) begin
      #1;
      check("bvalid_wait", {31'd0, BVALID}, 32'd1);
      @(negedge clk);
    end
    BREADY = 1'b1;
    #1;
    check("bvalid", {31'd0, BVALID}, 32'd1);
    check("bid", {24'd0, BID}, {24'd0, id});
    check("bresp", {30'd0, BRESP}, {30'd0, exp_resp});
    @(negedge clk);
    BREADY = 1'b0;
    #1;
    check("bvalid_clr", {31'd0, BVALID}, 32'd0);
  endtask

  // stall_beat >= 0 holds RREADY low stall_cycles cycles on that beat, otherwise RREADY is
  // always high; stall_beat < 0 gives random backpressure. abort_beat >= 0 pulses reset there.
  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input int stall_beat, input int stall_cycles, input int abort_beat);
    int b;
    int stalls;
    int unsigned t;
    ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
    #1;
    check("arready", {31'd0, ARREADY}, 32'd1);
    @(negedge clk);
    ARVALID = 1'b0;
    #1;
    check("r_lat_n1", {31'd0, RVALID}, 32'd0);
    check("rprep_ceb", {31'd0, SRAM_CEB}, 32'd0);
    check("rprep_addr", {18'd0, SRAM_A}, word_of(addr, 0));
    @(negedge clk);
    b = 0; stalls = 0; t = 0;
    while (b <= int'(len) && t < 200) begin
      if (b == stall_beat && stalls < stall_cycles) begin RREADY = 1'b0; stalls++; end
      else if (stall_beat < 0) RREADY = ($urandom_range(3) != 0);
      else RREADY = 1'b1;
      #1;
      if (b == abort_beat) begin
        rst = 1'b1;
        #1;
        check("rst_rvalid", {31'd0, RVALID}, 32'd0);
        check("rst_ceb", {31'd0, SRAM_CEB}, 32'd1);
        check("rst_rlast", {31'd0, RLAST}, 32'd0);
        @(negedge clk);
        rst = 1'b0; RREADY = 1'b0;
        return;
      end
      check("rvalid", {31'd0, RVALID}, 32'd1);
      check("rdata", RDATA, ref_mem[word_of(addr, b)]);
      check("rid", {24'd0, RID}, {24'd0, id});
      check("rresp", {30'd0, RRESP}, 32'd0);
      check("rlast", {31'd0, RLAST}, {31'd0, b == int'(len)});
      check("r_awready", {31'd0, AWREADY}, 32'd0);
      check("r_sram_a", {18'd0, SRAM_A}, word_of(addr, b + (RREADY ? 1 : 0)));
      if (RREADY) b++;
      @(negedge clk);
      t++;
    end
    RREADY = 1'b0;
    #1;
    check("r_done", {31'd0, RVALID}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sram[i]    = (i * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
      ref_mem[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    end

    #2;
    check("rst_rvalid", {31'd0, RVALID}, 32'd0);
    check("rst_wready", {31'd0, WREADY}, 32'd0);
    check("rst_bvalid", {31'd0, BVALID}, 32'd0);
    check("rst_rlast", {31'd0, RLAST}, 32'd0);
    check("rst_ceb", {31'd0, SRAM_CEB}, 32'd1);
    check("rst_web", {31'd0, SRAM_WEB}, 32'd1);
    check("rst_bweb", SRAM_BWEB, 32'hFFFF_FFFF);
    check("rst_ids", {16'd0, RID, BID}, 32'd0);
    check("rst_resps", {28'd0, RRESP, BRESP}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_arready", {31'd0, ARREADY}, 32'd1);
    @(negedge clk);

    // Single write then single read at word 4.
    wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF;
    axi_write(8'h11, 32'h0001_0010, 4'd0, -1, 2'b00);
    @(negedge clk);
    axi_read(8'h12, 32'h0001_0010, 4'd0, -1, 0, -1);
    @(negedge clk);

    // 4-beat read with a 3-cycle stall on beat 1.
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA000_0000 + i; wstb[i] = 4'hF; end
    axi_write(8'h21, 32'h0000_0100, 4'd3, -1, 2'b00);
    axi_read(8'h22, 32'h0000_0100, 4'd3, 1, 3, -1);

    // Byte strobes 0101 over all-ones.
    wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
    axi_write(8'h31, 32'h0000_0200, 4'd0, -1, 2'b00);
    wdat[0] = 32'h1122_3344; wstb[0] = 4'b0101;
    axi_write(8'h32, 32'h0000_0200, 4'd0, -1, 2'b00);
    axi_read(8'h33, 32'h0000_0200, 4'd0, 0, 0, -1);
    check("strobe_readback_ref", ref_mem[128], 32'hFF22_FF44);

    // Same-cycle AR/AW: read wins, AW stays pending and is taken after RLAST.
    @(negedge clk);
    AWID = 8'h41; AWADDR = 32'h0000_0300; AWLEN = 4'd1; AWVALID = 1'b1;
    ARVALID = 1'b1;
    #1;
    check("tie_arready", {31'd0, ARREADY}, 32'd1);
    check("tie_awready", {31'd0, AWREADY}, 32'd0);
    axi_read(8'h42, 32'h0000_0100, 4'd3, -1, 0, -1);
    wdat[0] = 32'h0BAD_F00D; wstb[0] = 4'hF;
    wdat[1] = 32'hCAFE_0001; wstb[1] = 4'b0011;
    axi_write(8'h41, 32'h0000_0300, 4'd1, -1, 2'b00);
    axi_read(8'h43, 32'h0000_0300, 4'd1, -1, 0, -1);

    // Early WLAST on a len=3 burst, then a clean write.
    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    axi_write(8'h51, 32'h0000_0400, 4'd3, 1, 2'b10);
    wdat[0] = $urandom; wstb[0] = 4'hF;
    axi_write(8'h52, 32'h0000_0410, 4'd0, -1, 2'b00);
    axi_read(8'h53, 32'h0000_0400, 4'd4, -1, 0, -1);

    // Reset during beat 2 of an 8-beat read, then a normal read.
    axi_read(8'h61, 32'h0000_0500, 4'd7, 5, 0, 2);
    axi_read(8'h62, 32'h0000_0500, 4'd7, -1, 0, -1);

    // Randomized bursts, including ones that wrap the word address.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int unsigned w;
      logic [3:0]  l;
      w = ($urandom_range(3) == 0) ? $urandom_range(DEPTH - 8, DEPTH - 1) : $urandom_range(0, 63);
      a = ($urandom & 32'hFFFF_0000) | (w << 2) | $urandom_range(3);
      l = 4'($urandom_range(15));
      if ($urandom_range(1) == 0) begin
        for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
        axi_write(8'($urandom), a, l, -1, 2'b00);
      end else begin
        axi_read(8'($urandom), a, l, -1, 0, -1);
      end
      if ($urandom_range(1) == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI4 slave that terminates one interconnect slave port and drives one synchronous single-port SRAM macro (instruction or data memory).
Sits directly downstream of the bus that the CPU-side AXI masters (IM on M0, DM on M1) reach through the interconnect.
Supports INCR bursts of 1-16 words with one beat per cycle for both reads and writes.
Handles one transaction at a time; reads and writes are never overlapped.

Parameters:
ID_W, 8, slave-side AXI ID width (master ID plus interconnect tag)
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width; fixed at 32 (4 byte lanes)
SRAM_AW, 14, SRAM word-address width (16K words = 64 KB)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
AR channel: ARID in ID_W, ARADDR in ADDR_W, ARLEN in 4, ARSIZE in 3, ARBURST in 2, ARVALID in 1, ARREADY out 1
R channel: RID out ID_W, RDATA out 32, RRESP out 2, RLAST out 1, RVALID out 1, RREADY in 1
AW channel: AWID in ID_W, AWADDR in ADDR_W, AWLEN in 4, AWSIZE in 3, AWBURST in 2, AWVALID in 1, AWREADY out 1
W channel: WDATA in 32, WSTRB in 4, WLAST in 1, WVALID in 1, WREADY out 1
B channel: BID out ID_W, BRESP out 2, BVALID out 1, BREADY in 1
SRAM_CEB out 1 (active-low chip enable), SRAM_WEB out 1 (0 = write)
SRAM_BWEB out 32 (active-low bit write enable), SRAM_A out SRAM_AW, SRAM_DI out 32, SRAM_DO in 32 (valid 1 cycle after a read)

Behaviour:
- States: IDLE, RPREP, RDATA, WDATA, WRESP. Reset (async, any state) forces IDLE and drops any partial burst; no B response is issued for it.
- Reset outputs: RVALID=0, WREADY=0, BVALID=0, RLAST=0, SRAM_CEB=1, SRAM_WEB=1, SRAM_BWEB=all 1, RID/BID/RRESP/BRESP=0.
- IDLE: ARREADY=1. AWREADY=~ARVALID, so a read wins a same-cycle AR/AW tie. The AW stays pending under AXI rules.
- AR handshake: latch ID, word address ADDR[SRAM_AW+1:2], LEN; clear beat counter; go to RPREP.
- RPREP: issue an SRAM read of the latched address (CEB=0, WEB=1); go to RDATA.
  - Address handshake at cycle N gives first RVALID at N+2.
- RDATA: RVALID=1, RDATA=SRAM_DO, RID=latched ID, RRESP=OKAY (2'b00), RLAST=(cnt==LEN).
  - SRAM_A = RREADY ? addr+1 : addr, with CEB=0 every cycle. On a stall the current word is re-read, so RDATA stays stable.
  - On handshake: addr++, cnt++. If RLAST, go to IDLE; the extra SRAM read issued is harmless.
- AW handshake: latch ID, address, LEN; clear counter; go to WDATA.
- WDATA: WREADY=1.
  - On W handshake: CEB=0, WEB=0, A=addr, DI=WDATA, BWEB[8i+7:8i]={8{~WSTRB[i]}}; addr++, cnt++.
  - Outside a handshake: CEB=1.
  - The burst ends on the beat where cnt==LEN, regardless of WLAST.
  - Set a sticky error bit if WLAST differs from (cnt==LEN) on any beat. Go to WRESP.
- WRESP: BVALID=1, BID=latched ID, BRESP = error ? SLVERR (2'b10) : OKAY. On BREADY, clear error and go to IDLE.
- ARSIZE/AWSIZE are ignored; all beats are 32-bit. ARBURST/AWBURST are treated as INCR.
- The word address wraps modulo 2^SRAM_AW. Address bits above SRAM_AW+1 are ignored, since decoding is done by the interconnect.
- BWEB mapping: WSTRB=4'b0011 gives BWEB=32'hFFFF_0000.

Decomposition:
- Shared package axi_slv_pkg: state enum, RESP_OKAY/RESP_SLVERR, BURST_INCR constants, plus LEN/SIZE widths taken from the existing AXI define header.
- No sub-module; the address/beat counter and strobe expansion are inline.

Test Plan:
- Single write then single read: AW addr 0x0001_0010 len 0, W 0xDEADBEEF strb 4'hF, WLAST=1 -> SRAM_A=4, BRESP=00. AR same addr -> RVALID at N+2, RDATA=0xDEADBEEF, RLAST=1.
- 4-beat read with RREADY low for 3 cycles on beat 1 -> RDATA holds beat-1 value through the stall; beats 0..3 arrive in order; RLAST only on beat 3.
- Byte strobe: write 0x11223344 strb 4'b0101 over 0xFFFFFFFF -> read back 0xFF22FF44.
- Same-cycle ARVALID and AWVALID in IDLE -> AR accepted first, AWREADY=0. AW accepted in IDLE after RLAST; read data is not corrupted.
- WLAST on beat 1 of a len=3 burst -> 4 beats still accepted, BRESP=2'b10; next write's BRESP=00.
- rst pulsed during beat 2 of an 8-beat read -> RVALID=0, SRAM_CEB=1 asynchronously. A new AR is accepted normally after release.
